// File: rtl/rv32im_decode_execute_if.sv
// Decode/execute slice bus: ID-stage inputs toward the slice, ID/EX results toward MEM/fetch.
interface rv32im_decode_execute_if;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [31:0] IMM;
    logic [31:0] ALU_OUT;
    logic        BRANCH_TAKEN;
    logic [31:0] LINK_PC;
    logic [31:0] STORE_DATA;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic        REG_WRITE_EN;
    logic [1:0]  REG_WRITE_SELECT;
    logic [4:0]  REG_WRITE_ADDR;

    modport master (
        output STALL, FLUSH, INSTRUCTION, PC, DATA1, DATA2, IMM,
        input  ALU_OUT, BRANCH_TAKEN, LINK_PC, STORE_DATA, MEM_READ, MEM_WRITE,
               REG_WRITE_EN, REG_WRITE_SELECT, REG_WRITE_ADDR
    );

    modport slave (
        input  STALL, FLUSH, INSTRUCTION, PC, DATA1, DATA2, IMM,
        output ALU_OUT, BRANCH_TAKEN, LINK_PC, STORE_DATA, MEM_READ, MEM_WRITE,
               REG_WRITE_EN, REG_WRITE_SELECT, REG_WRITE_ADDR
    );
endinterface

// File: rtl/rv32im_decode_execute.sv
// RV32IM decode + execute slice: decodes into one ID/EX register, then computes
// the ALU result and branch decision combinationally from the latched fields.
module rv32im_decode_execute (
    input logic                     CLK,
    input logic                     RESET,
    rv32im_decode_execute_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] WSEL_ALU  = 2'b01;
    localparam logic [1:0] WSEL_LINK = 2'b11;
    localparam logic [3:0] BR_JUMP   = 4'b1010;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000, ALU_SLL  = 5'b00001, ALU_SLT    = 5'b00010, ALU_SLTU  = 5'b00011,
        ALU_XOR  = 5'b00100, ALU_SRL  = 5'b00101, ALU_OR     = 5'b00110, ALU_AND   = 5'b00111,
        ALU_MUL  = 5'b01000, ALU_MULH = 5'b01001, ALU_MULHSU = 5'b01010, ALU_MULHU = 5'b01011,
        ALU_DIV  = 5'b01100, ALU_DIVU = 5'b01101, ALU_REM    = 5'b01110, ALU_REMU  = 5'b01111,
        ALU_SUB  = 5'b10000, ALU_SRA  = 5'b10101, ALU_PASSB  = 5'b11111
    } alu_op_e;

    typedef struct packed {
        logic [4:0]      alu_op;
        logic            op1_sel;
        logic            op2_sel;
        logic            clr_bit0;
        logic [3:0]      branch_sel;
        logic [3:0]      mem_read;
        logic [2:0]      mem_write;
        logic            reg_write_en;
        logic [1:0]      wsel;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] link_pc;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
    } idex_t;

    idex_t      dec_c;
    idex_t      idex_q;
    logic       legal_c;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = bus.INSTRUCTION[6:0];
    assign funct3 = bus.INSTRUCTION[14:12];
    assign funct7 = bus.INSTRUCTION[31:25];

    // Instruction decode; anything not recognised collapses to an all-zero NOP.
    always_comb begin
        dec_c   = '0;
        legal_c = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal_c = 1'b1; dec_c.op2_sel = 1'b1; dec_c.alu_op = ALU_PASSB;
                dec_c.reg_write_en = 1'b1; dec_c.wsel = WSEL_ALU;
            end
            OPC_AUIPC: begin
                legal_c = 1'b1; dec_c.op1_sel = 1'b1; dec_c.op2_sel = 1'b1;
                dec_c.reg_write_en = 1'b1; dec_c.wsel = WSEL_ALU;
            end
            OPC_JAL: begin
                legal_c = 1'b1; dec_c.op1_sel = 1'b1; dec_c.op2_sel = 1'b1;
                dec_c.branch_sel = BR_JUMP; dec_c.reg_write_en = 1'b1; dec_c.wsel = WSEL_LINK;
            end
            OPC_JALR: begin
                legal_c = 1'b1; dec_c.op2_sel = 1'b1; dec_c.clr_bit0 = 1'b1;
                dec_c.branch_sel = BR_JUMP; dec_c.reg_write_en = 1'b1; dec_c.wsel = WSEL_LINK;
            end
            OPC_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) begin
                legal_c = 1'b1; dec_c.op1_sel = 1'b1; dec_c.op2_sel = 1'b1;
                dec_c.branch_sel = {1'b1, funct3};
            end
            OPC_LOAD: if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                legal_c = 1'b1; dec_c.op2_sel = 1'b1; dec_c.mem_read = {1'b1, funct3};
                dec_c.reg_write_en = 1'b1;
            end
            OPC_STORE: if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                legal_c = 1'b1; dec_c.op2_sel = 1'b1; dec_c.mem_write = {1'b1, funct3[1:0]};
            end
            OPC_OPIMM: begin
                legal_c = 1'b1; dec_c.op2_sel = 1'b1;
                dec_c.alu_op = {funct7[5] && funct3 == 3'b101, 1'b0, funct3};
                dec_c.reg_write_en = 1'b1; dec_c.wsel = WSEL_ALU;
            end
            OPC_OP: begin
                legal_c = 1'b1; dec_c.reg_write_en = 1'b1; dec_c.wsel = WSEL_ALU;
                if (funct7 == 7'b0000001) dec_c.alu_op = {2'b01, funct3};
                else dec_c.alu_op = {funct7[5] && (funct3 == 3'b000 || funct3 == 3'b101), 1'b0, funct3};
            end
            default: ;
        endcase
        if (legal_c) begin
            dec_c.rd           = bus.INSTRUCTION[11:7];
            dec_c.reg_write_en = dec_c.reg_write_en && (bus.INSTRUCTION[11:7] != 5'd0);
            dec_c.pc           = bus.PC;
            dec_c.link_pc      = bus.PC + XLEN'(4);
            dec_c.data1        = bus.DATA1;
            dec_c.data2        = bus.DATA2;
            dec_c.imm          = bus.IMM;
        end else begin
            dec_c = '0;
        end
    end

    // ID/EX register: reset, then stall-hold, then flush-to-NOP.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idex_q <= '0;
        end else if (!bus.STALL) begin
            if (bus.FLUSH) idex_q <= '0;
            else           idex_q <= dec_c;
        end
    end

    logic [XLEN-1:0]   op1, op2, alu_res;
    logic [4:0]        shamt;
    logic [2*XLEN-1:0] prod_ss, prod_su, prod_uu;
    logic              div_ovf;
    logic              unused_bits;

    assign op1     = idex_q.op1_sel ? idex_q.pc  : idex_q.data1;
    assign op2     = idex_q.op2_sel ? idex_q.imm : idex_q.data2;
    assign shamt   = op2[4:0];
    assign prod_ss = {{XLEN{op1[XLEN-1]}}, op1} * {{XLEN{op2[XLEN-1]}}, op2};
    assign prod_su = {{XLEN{op1[XLEN-1]}}, op1} * {{XLEN{1'b0}}, op2};
    assign prod_uu = {{XLEN{1'b0}}, op1} * {{XLEN{1'b0}}, op2};
    assign div_ovf = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
    assign unused_bits = ^{bus.INSTRUCTION[24:15], prod_su[XLEN-1:0], prod_uu[XLEN-1:0]};

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(idex_q.alu_op))
            ALU_ADD:    alu_res = op1 + op2;
            ALU_SUB:    alu_res = op1 - op2;
            ALU_SLL:    alu_res = op1 << shamt;
            ALU_SRL:    alu_res = op1 >> shamt;
            ALU_SRA:    alu_res = XLEN'($signed(op1) >>> shamt);
            ALU_SLT:    alu_res = XLEN'($signed(op1) < $signed(op2));
            ALU_SLTU:   alu_res = XLEN'(op1 < op2);
            ALU_XOR:    alu_res = op1 ^ op2;
            ALU_OR:     alu_res = op1 | op2;
            ALU_AND:    alu_res = op1 & op2;
            ALU_MUL:    alu_res = prod_ss[XLEN-1:0];
            ALU_MULH:   alu_res = prod_ss[2*XLEN-1:XLEN];
            ALU_MULHSU: alu_res = prod_su[2*XLEN-1:XLEN];
            ALU_MULHU:  alu_res = prod_uu[2*XLEN-1:XLEN];
            ALU_DIV:    alu_res = (op2 == '0) ? {XLEN{1'b1}} :
                                  div_ovf ? op1 : XLEN'($signed(op1) / $signed(op2));
            ALU_DIVU:   alu_res = (op2 == '0) ? {XLEN{1'b1}} : op1 / op2;
            ALU_REM:    alu_res = (op2 == '0) ? op1 :
                                  div_ovf ? '0 : XLEN'($signed(op1) % $signed(op2));
            ALU_REMU:   alu_res = (op2 == '0) ? op1 : op1 % op2;
            ALU_PASSB:  alu_res = op2;
            default:    alu_res = '0;
        endcase
    end

    // Branch compare uses the raw register operands, not the ALU operand mux.
    logic taken_c;
    always_comb begin
        taken_c = 1'b0;
        case (idex_q.branch_sel)
            4'b1000: taken_c = idex_q.data1 == idex_q.data2;
            4'b1001: taken_c = idex_q.data1 != idex_q.data2;
            4'b1100: taken_c = $signed(idex_q.data1) <  $signed(idex_q.data2);
            4'b1101: taken_c = $signed(idex_q.data1) >= $signed(idex_q.data2);
            4'b1110: taken_c = idex_q.data1 <  idex_q.data2;
            4'b1111: taken_c = idex_q.data1 >= idex_q.data2;
            BR_JUMP: taken_c = 1'b1;
            default: taken_c = 1'b0;
        endcase
    end

    assign bus.ALU_OUT          = idex_q.clr_bit0 ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
    assign bus.BRANCH_TAKEN     = taken_c;
    assign bus.LINK_PC          = idex_q.link_pc;
    assign bus.STORE_DATA       = idex_q.data2;
    assign bus.MEM_READ         = idex_q.mem_read;
    assign bus.MEM_WRITE        = idex_q.mem_write;
    assign bus.REG_WRITE_EN     = idex_q.reg_write_en;
    assign bus.REG_WRITE_SELECT = idex_q.wsel;
    assign bus.REG_WRITE_ADDR   = idex_q.rd;
endmodule

// File: tb/tb_rv32im_decode_execute.sv
// Directed bench for rv32im_decode_execute: each step queues its expected ID/EX
// outputs, and the entry is popped and compared one cycle later.
module tb_rv32im_decode_execute;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    rv32im_decode_execute_if bus ();

    rv32im_decode_execute dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic        taken;
        logic [31:0] link;
        logic [31:0] sdata;
        logic [3:0]  mrd;
        logic [2:0]  mwr;
        logic        we;
        logic [1:0]  wsel;
        logic [4:0]  waddr;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    function automatic exp_t mk(string tag, logic [31:0] alu, logic taken, logic [31:0] link,
                                logic [31:0] sdata, logic [3:0] mrd, logic [2:0] mwr,
                                logic we, logic [1:0] wsel, logic [4:0] waddr);
        exp_t e;
        e.tag = tag; e.alu = alu; e.taken = taken; e.link = link; e.sdata = sdata;
        e.mrd = mrd; e.mwr = mwr; e.we = we; e.wsel = wsel; e.waddr = waddr;
        return e;
    endfunction

    task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Drive one instruction, queue its expectation, clock it and compare after the edge.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic stall,
                        input logic flush, input exp_t e);
        exp_t got;
        bus.INSTRUCTION = instr; bus.PC = pc; bus.DATA1 = d1; bus.DATA2 = d2; bus.IMM = imm;
        bus.STALL = stall; bus.FLUSH = flush;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        chk(got.tag, "alu_out", bus.ALU_OUT,                 got.alu);
        chk(got.tag, "taken",   32'(bus.BRANCH_TAKEN),       32'(got.taken));
        chk(got.tag, "link_pc", bus.LINK_PC,                 got.link);
        chk(got.tag, "st_data", bus.STORE_DATA,              got.sdata);
        chk(got.tag, "mem_rd",  32'(bus.MEM_READ),           32'(got.mrd));
        chk(got.tag, "mem_wr",  32'(bus.MEM_WRITE),          32'(got.mwr));
        chk(got.tag, "we",      32'(bus.REG_WRITE_EN),       32'(got.we));
        chk(got.tag, "wsel",    32'(bus.REG_WRITE_SELECT),   32'(got.wsel));
        chk(got.tag, "waddr",   32'(bus.REG_WRITE_ADDR),     32'(got.waddr));
        last = got;
    endtask

    exp_t nop;

    initial begin
        nop = mk("nop", 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 1'b0, 2'b00, 5'd0);

        // Reset wins over a stall and a live ADD on the inputs.
        RESET = 1'b1;
        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, 1'b1, 1'b0,
             mk("reset", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        RESET = 1'b0;

        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0,
             mk("add", 32'd12, 0, 32'h4, 32'd7, 0, 0, 1, 2'b01, 5'd3));
        step(32'h402081B3, 32'h0, 32'h80000000, 32'd1, 32'h0, 1'b0, 1'b0,
             mk("sub", 32'h7FFFFFFF, 0, 32'h4, 32'd1, 0, 0, 1, 2'b01, 5'd3));
        step(32'h4020D1B3, 32'h0, 32'h80000000, 32'd1, 32'h0, 1'b0, 1'b0,
             mk("sra", 32'hC0000000, 0, 32'h4, 32'd1, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0020A1B3, 32'h0, 32'h80000000, 32'd1, 32'h0, 1'b0, 1'b0,
             mk("slt", 32'd1, 0, 32'h4, 32'd1, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0020B1B3, 32'h0, 32'h80000000, 32'd1, 32'h0, 1'b0, 1'b0,
             mk("sltu", 32'd0, 0, 32'h4, 32'd1, 0, 0, 1, 2'b01, 5'd3));
        step(32'h022081B3, 32'h0, 32'd3, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0,
             mk("mul", 32'hFFFFFFFA, 0, 32'h4, 32'hFFFFFFFE, 0, 0, 1, 2'b01, 5'd3));
        step(32'h022091B3, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0,
             mk("mulh", 32'h0, 0, 32'h4, 32'hFFFFFFFF, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220A1B3, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0,
             mk("mulhsu", 32'hFFFFFFFF, 0, 32'h4, 32'hFFFFFFFF, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220B1B3, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0,
             mk("mulhu", 32'hFFFFFFFE, 0, 32'h4, 32'hFFFFFFFF, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220C1B3, 32'h0, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0,
             mk("div0", 32'hFFFFFFFF, 0, 32'h4, 32'd0, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220E1B3, 32'h0, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0,
             mk("rem0", 32'd7, 0, 32'h4, 32'd0, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220C1B3, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0,
             mk("div_ovf", 32'h80000000, 0, 32'h4, 32'hFFFFFFFF, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220E1B3, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0,
             mk("rem_ovf", 32'h0, 0, 32'h4, 32'hFFFFFFFF, 0, 0, 1, 2'b01, 5'd3));
        step(32'h0220C1B3, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0,
             mk("div_neg", 32'hFFFFFFFD, 0, 32'h4, 32'd2, 0, 0, 1, 2'b01, 5'd3));

        // OP-IMM: SRAI keys on funct7[5]; ADDI with the same immediate bit must stay an add.
        step(32'h4010D193, 32'h0, 32'h80000000, 32'h0, 32'h00000401, 1'b0, 1'b0,
             mk("srai", 32'hC0000000, 0, 32'h4, 32'h0, 0, 0, 1, 2'b01, 5'd3));
        step(32'h40008193, 32'h0, 32'd1, 32'h0, 32'h00000400, 1'b0, 1'b0,
             mk("addi", 32'h401, 0, 32'h4, 32'h0, 0, 0, 1, 2'b01, 5'd3));
        step(32'h00008013, 32'h0, 32'd1, 32'h0, 32'd9, 1'b0, 1'b0,
             mk("addi_x0", 32'd10, 0, 32'h4, 32'h0, 0, 0, 0, 2'b01, 5'd0));

        step(32'h00208063, 32'h100, 32'd3, 32'd3, 32'd8, 1'b0, 1'b0,
             mk("beq", 32'h108, 1, 32'h104, 32'd3, 0, 0, 0, 2'b00, 5'd0));
        step(32'h00209063, 32'h100, 32'd3, 32'd3, 32'd8, 1'b0, 1'b0,
             mk("bne", 32'h108, 0, 32'h104, 32'd3, 0, 0, 0, 2'b00, 5'd0));
        step(32'h0020E063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8, 1'b0, 1'b0,
             mk("bltu", 32'h108, 0, 32'h104, 32'd1, 0, 0, 0, 2'b00, 5'd0));
        step(32'h0020C063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8, 1'b0, 1'b0,
             mk("blt", 32'h108, 1, 32'h104, 32'd1, 0, 0, 0, 2'b00, 5'd0));
        step(32'h000080E7, 32'h20, 32'h41, 32'h0, 32'h0, 1'b0, 1'b0,
             mk("jalr", 32'h40, 1, 32'h24, 32'h0, 0, 0, 1, 2'b11, 5'd1));
        step(32'h000000EF, 32'h40, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0,
             mk("jal", 32'h50, 1, 32'h44, 32'h0, 0, 0, 1, 2'b11, 5'd1));
        step(32'h00000297, 32'h1000, 32'h0, 32'h0, 32'h2000, 1'b0, 1'b0,
             mk("auipc", 32'h3000, 0, 32'h1004, 32'h0, 0, 0, 1, 2'b01, 5'd5));
        step(32'h0020A023, 32'h0, 32'h1000, 32'hCAFE, 32'd4, 1'b0, 1'b0,
             mk("sw", 32'h1004, 0, 32'h4, 32'hCAFE, 4'h0, 3'b110, 0, 2'b00, 5'd0));
        step(32'h0000C203, 32'h0, 32'h200, 32'h0, 32'd3, 1'b0, 1'b0,
             mk("lbu", 32'h203, 0, 32'h4, 32'h0, 4'b1100, 3'h0, 1, 2'b00, 5'd4));
        step(32'h0000007F, 32'h80, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, nop);

        // Stall holds the register (even with flush asserted); flush alone yields a NOP.
        step(32'h000002B7, 32'h10, 32'h0, 32'h5, 32'h12345000, 1'b0, 1'b0,
             mk("lui", 32'h12345000, 0, 32'h14, 32'h5, 0, 0, 1, 2'b01, 5'd5));
        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, 1'b1, 1'b0,
             mk("stall", 32'h12345000, 0, 32'h14, 32'h5, 0, 0, 1, 2'b01, 5'd5));
        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, 1'b1, 1'b1,
             mk("stall_flush", 32'h12345000, 0, 32'h14, 32'h5, 0, 0, 1, 2'b01, 5'd5));
        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1,
             mk("flush", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
